// File: rtl/wb_timer.sv
// ---------------------------------------------------------------------------
// wb_timer -- Wishbone timer slave (main NIC slot 2)
//
// Prescaled up-counter with compare match, overflow flag, optional
// auto-reload and a level interrupt. Software either polls STATUS or takes
// o_irq for periodic ticks / timeouts.
//
// Optional feature macro: WB_TIMER_PWM_EN
//   defined   : DUTY register at word 4, o_pwm = EN & (COUNT < DUTY), one
//               clock behind COUNT.
//   undefined : word 4 reads 0 and ignores writes, o_pwm is tied low and no
//               DUTY flops exist.
//
// Register map (word address i_wb_adr[2:0]):
//   0 CTRL    [0] EN  [1] IRQ_EN  [2] RELOAD  [15:8] PSC
//   1 COUNT   read/write
//   2 COMPARE read/write
//   3 STATUS  [0] MATCH  [1] OVF  (write 1 to clear)
//   4 DUTY    (PWM build only)
//   5..7      read 0, writes ignored, still acknowledged
//
// Ports:
//   i_clk      core clock
//   i_reset    asynchronous active-high reset
//   i_dev_sel  NIC slave select for this slot
//   i_wb_adr   word address (bus addr[11:2]); only [2:0] decoded
//   i_wb_dat   write data
//   o_wb_dat   read data, valid while o_wb_ack=1, otherwise 0
//   i_wb_we    1 = write
//   i_wb_sel   byte enables for writes
//   i_wb_cyc   bus cycle active
//   o_wb_ack   single-cycle acknowledge
//   o_irq      level interrupt: IRQ_EN & (MATCH | OVF)
//   o_pwm      PWM output
// ---------------------------------------------------------------------------
module wb_timer #(
  parameter int CNT_WIDTH = 32,
  parameter int PSC_WIDTH = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_dev_sel,
  input  logic [9:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  output logic [31:0] o_wb_dat,
  input  logic        i_wb_we,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_cyc,
  output logic        o_wb_ack,
  output logic        o_irq,
  output logic        o_pwm
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONES = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [PSC_WIDTH-1:0] PSC_ZERO = {PSC_WIDTH{1'b0}};

  localparam logic [2:0] ADR_CTRL    = 3'd0;
  localparam logic [2:0] ADR_COUNT   = 3'd1;
  localparam logic [2:0] ADR_COMPARE = 3'd2;
  localparam logic [2:0] ADR_STATUS  = 3'd3;
  localparam logic [2:0] ADR_DUTY    = 3'd4;

  // Byte-lane merge of a write into the current 32-bit register image.
  function automatic logic [31:0] merge_lanes(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  sel
  );
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

  // ---------------------------------------------------------------- state
  logic                 en_q,      en_d;
  logic                 irq_en_q,  irq_en_d;
  logic                 reload_q,  reload_d;
  logic [PSC_WIDTH-1:0] psc_cfg_q, psc_cfg_d;
  logic [PSC_WIDTH-1:0] psc_q,     psc_d;
  logic [CNT_WIDTH-1:0] count_q,   count_d;
  logic [CNT_WIDTH-1:0] compare_q, compare_d;
  logic                 match_q,   match_d;
  logic                 ovf_q,     ovf_d;
  logic                 ack_q,     ack_d;
  logic [31:0]          rdat_q,    rdat_d;
`ifdef WB_TIMER_PWM_EN
  logic [CNT_WIDTH-1:0] duty_q,    duty_d;
  logic                 pwm_q,     pwm_d;
`endif

  // ---------------------------------------------------------------- decode
  logic        acc_s, wr_s, rd_s;
  logic        wr_ctrl_s, wr_count_s, wr_compare_s, wr_status_s;
  logic [31:0] ctrl_img_s, count_img_s, compare_img_s, status_img_s;
  logic [31:0] ctrl_new_s, count_new_s, compare_new_s;
  logic [31:0] rd_mux_s;
  logic        tick_s, match_hit_s, ovf_hit_s;
  logic        clr_match_s, clr_ovf_s;
`ifdef WB_TIMER_PWM_EN
  logic        wr_duty_s;
  logic [31:0] duty_img_s, duty_new_s;
`endif

  // Bus access decode, register images and the read mux.
  always_comb begin
    // An access is only taken while no ack is pending, so acks never
    // appear back to back even with i_wb_cyc held high.
    acc_s        = i_dev_sel & i_wb_cyc & ~ack_q;
    wr_s         = acc_s & i_wb_we;
    rd_s         = acc_s & ~i_wb_we;
    wr_ctrl_s    = wr_s & (i_wb_adr[2:0] == ADR_CTRL);
    wr_count_s   = wr_s & (i_wb_adr[2:0] == ADR_COUNT);
    wr_compare_s = wr_s & (i_wb_adr[2:0] == ADR_COMPARE);
    wr_status_s  = wr_s & (i_wb_adr[2:0] == ADR_STATUS);

    ctrl_img_s                   = 32'h0000_0000;
    ctrl_img_s[0]                = en_q;
    ctrl_img_s[1]                = irq_en_q;
    ctrl_img_s[2]                = reload_q;
    ctrl_img_s[8 +: PSC_WIDTH]   = psc_cfg_q;
    count_img_s                  = 32'h0000_0000;
    count_img_s[CNT_WIDTH-1:0]   = count_q;
    compare_img_s                = 32'h0000_0000;
    compare_img_s[CNT_WIDTH-1:0] = compare_q;
    status_img_s                 = {30'h0000_0000, ovf_q, match_q};

    ctrl_new_s    = merge_lanes(ctrl_img_s, i_wb_dat, i_wb_sel);
    count_new_s   = merge_lanes(count_img_s, i_wb_dat, i_wb_sel);
    compare_new_s = merge_lanes(compare_img_s, i_wb_dat, i_wb_sel);

`ifdef WB_TIMER_PWM_EN
    wr_duty_s                 = wr_s & (i_wb_adr[2:0] == ADR_DUTY);
    duty_img_s                = 32'h0000_0000;
    duty_img_s[CNT_WIDTH-1:0] = duty_q;
    duty_new_s                = merge_lanes(duty_img_s, i_wb_dat, i_wb_sel);
`endif

    case (i_wb_adr[2:0])
      ADR_CTRL:    rd_mux_s = ctrl_img_s;
      ADR_COUNT:   rd_mux_s = count_img_s;
      ADR_COMPARE: rd_mux_s = compare_img_s;
      ADR_STATUS:  rd_mux_s = status_img_s;
`ifdef WB_TIMER_PWM_EN
      ADR_DUTY:    rd_mux_s = duty_img_s;
`else
      ADR_DUTY:    rd_mux_s = 32'h0000_0000;
`endif
      default:     rd_mux_s = 32'h0000_0000;
    endcase
  end

  // Prescaler tick and counter event detection.
  always_comb begin
    tick_s      = en_q & (psc_q == psc_cfg_q);
    match_hit_s = tick_s & (count_q == compare_q);
    // With RELOAD the match wrap goes to 0 without passing through
    // all-ones, so it is not an overflow even when COMPARE is all-ones.
    ovf_hit_s   = tick_s & (count_q == CNT_ONES) & ~(match_hit_s & reload_q);
    clr_match_s = wr_status_s & i_wb_sel[0] & i_wb_dat[0];
    clr_ovf_s   = wr_status_s & i_wb_sel[0] & i_wb_dat[1];
  end

  // Next-state logic for control, prescaler, counter, flags and bus.
  always_comb begin
    en_d      = en_q;
    irq_en_d  = irq_en_q;
    reload_d  = reload_q;
    psc_cfg_d = psc_cfg_q;
    psc_d     = psc_q;
    count_d   = count_q;
    compare_d = compare_q;
    match_d   = match_q;
    ovf_d     = ovf_q;
    ack_d     = acc_s;
    rdat_d    = 32'h0000_0000;

    if (wr_ctrl_s) begin
      en_d      = ctrl_new_s[0];
      irq_en_d  = ctrl_new_s[1];
      reload_d  = ctrl_new_s[2];
      psc_cfg_d = ctrl_new_s[8 +: PSC_WIDTH];
    end else begin
      psc_cfg_d = psc_cfg_q;
    end

    // Prescaler phase restarts whenever the PSC byte is written so a new
    // period always starts cleanly.
    if (!en_q) begin
      psc_d = PSC_ZERO;
    end else if (wr_ctrl_s && i_wb_sel[1]) begin
      psc_d = PSC_ZERO;
    end else if (tick_s) begin
      psc_d = PSC_ZERO;
    end else begin
      psc_d = psc_q + PSC_WIDTH'(1);
    end

    // A software write to COUNT overrides the tick update for that cycle;
    // the flags below still see the tick.
    if (wr_count_s) begin
      count_d = count_new_s[CNT_WIDTH-1:0];
    end else if (match_hit_s && reload_q) begin
      count_d = CNT_ZERO;
    end else if (tick_s) begin
      count_d = count_q + CNT_WIDTH'(1);
    end else begin
      count_d = count_q;
    end

    if (wr_compare_s) begin
      compare_d = compare_new_s[CNT_WIDTH-1:0];
    end else begin
      compare_d = compare_q;
    end

    // Hardware set takes priority over a same-cycle write-1-to-clear.
    match_d = match_hit_s | (match_q & ~clr_match_s);
    ovf_d   = ovf_hit_s   | (ovf_q   & ~clr_ovf_s);

    if (rd_s) begin
      rdat_d = rd_mux_s;
    end else begin
      rdat_d = 32'h0000_0000;
    end
  end

`ifdef WB_TIMER_PWM_EN
  // DUTY register and the registered PWM compare.
  always_comb begin
    duty_d = duty_q;
    if (wr_duty_s) begin
      duty_d = duty_new_s[CNT_WIDTH-1:0];
    end else begin
      duty_d = duty_q;
    end
    pwm_d = en_q & (count_q < duty_q);
  end

  // DUTY/PWM state register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      duty_q <= CNT_ZERO;
      pwm_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign o_pwm = pwm_q;
`else
  assign o_pwm = 1'b0;
`endif

  // Main state register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      en_q      <= 1'b0;
      irq_en_q  <= 1'b0;
      reload_q  <= 1'b0;
      psc_cfg_q <= PSC_ZERO;
      psc_q     <= PSC_ZERO;
      count_q   <= CNT_ZERO;
      compare_q <= CNT_ZERO;
      match_q   <= 1'b0;
      ovf_q     <= 1'b0;
      ack_q     <= 1'b0;
      rdat_q    <= 32'h0000_0000;
    end else begin
      en_q      <= en_d;
      irq_en_q  <= irq_en_d;
      reload_q  <= reload_d;
      psc_cfg_q <= psc_cfg_d;
      psc_q     <= psc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      match_q   <= match_d;
      ovf_q     <= ovf_d;
      ack_q     <= ack_d;
      rdat_q    <= rdat_d;
    end
  end

  assign o_wb_ack = ack_q;
  assign o_wb_dat = rdat_q;
  assign o_irq    = irq_en_q & (match_q | ovf_q);

  // Address bits above the decoded range and unassigned CTRL bits.
  logic unused_s;
  assign unused_s = ^{i_wb_adr[9:3], ctrl_new_s[31:16], ctrl_new_s[7:3]};

endmodule

// File: tb/tb_wb_timer.sv
// Self-checking bench for wb_timer: directed scenarios plus randomized bus
// traffic, all compared cycle by cycle against a behavioural model.
module tb_wb_timer;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_dev_sel;
  logic [9:0]  i_wb_adr;
  logic [31:0] i_wb_dat;
  logic [31:0] o_wb_dat;
  logic        i_wb_we;
  logic [3:0]  i_wb_sel;
  logic        i_wb_cyc;
  logic        o_wb_ack;
  logic        o_irq;
  logic        o_pwm;

  int n_checks = 0;
  int n_errors = 0;

  wb_timer dut (
    .i_clk(clk), .i_reset(i_reset), .i_dev_sel(i_dev_sel),
    .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .o_wb_dat(o_wb_dat),
    .i_wb_we(i_wb_we), .i_wb_sel(i_wb_sel), .i_wb_cyc(i_wb_cyc),
    .o_wb_ack(o_wb_ack), .o_irq(o_irq), .o_pwm(o_pwm)
  );

  always #5 clk = ~clk;

  // Reference model state (spec-level view of the timer).
  logic        m_en, m_irq_en, m_reload;
  logic [7:0]  m_psc;
  int          m_phase;       // clocks since the prescaler last restarted
  logic [31:0] m_count, m_compare, m_duty;
  logic        m_match, m_ovf, m_ack, m_pwm;
  logic [31:0] m_rdat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? n[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_ctrl();
    return {16'h0000, m_psc, 5'h00, m_reload, m_irq_en, m_en};
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return m_ctrl();
      3'd1: return m_count;
      3'd2: return m_compare;
      3'd3: return {30'h0, m_ovf, m_match};
`ifdef WB_TIMER_PWM_EN
      3'd4: return m_duty;
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_reset();
    m_en = 1'b0; m_irq_en = 1'b0; m_reload = 1'b0; m_psc = 8'h00; m_phase = 0;
    m_count = 32'h0; m_compare = 32'h0; m_duty = 32'h0;
    m_match = 1'b0; m_ovf = 1'b0; m_ack = 1'b0; m_pwm = 1'b0; m_rdat = 32'h0;
  endfunction

  // Compare every observable output with the model.
  task automatic check_outputs();
    check("ack",  32'(o_wb_ack), 32'(m_ack));
    check("rdat", o_wb_dat, m_rdat);
    check("irq",  32'(o_irq), 32'(m_irq_en & (m_match | m_ovf)));
    check("pwm",  32'(o_pwm), 32'(m_pwm));
  endtask

  // Advance one clock: predict from current inputs, clock, then compare.
  task automatic step();
    logic        acc, wr, tick, hit, set_o, clr_m, clr_o;
    logic [2:0]  a;
    logic [32:0] inc;
    logic [31:0] img, n_count, n_compare, n_duty, n_rdat;
    logic        n_en, n_irq_en, n_reload, n_match, n_ovf, n_pwm;
    logic [7:0]  n_psc;
    int          n_phase;
    a      = i_wb_adr[2:0];
    acc    = i_dev_sel && i_wb_cyc && !m_ack;
    wr     = acc && i_wb_we;
    n_rdat = (acc && !i_wb_we) ? m_read(a) : 32'h0;
    tick   = m_en && ((m_phase % (int'(m_psc) + 1)) == int'(m_psc));
    hit    = tick && (m_count == m_compare);
    inc    = {1'b0, m_count} + 33'd1;
    set_o  = tick && inc[32] && !(hit && m_reload);
    n_count = m_count;
    if (tick) n_count = (hit && m_reload) ? 32'h0 : inc[31:0];
    if (wr && a == 3'd1) n_count = lanes(m_count, i_wb_dat, i_wb_sel);
    clr_m   = wr && a == 3'd3 && i_wb_sel[0] && i_wb_dat[0];
    clr_o   = wr && a == 3'd3 && i_wb_sel[0] && i_wb_dat[1];
    n_match = hit   || (m_match && !clr_m);
    n_ovf   = set_o || (m_ovf && !clr_o);
    n_en = m_en; n_irq_en = m_irq_en; n_reload = m_reload; n_psc = m_psc;
    if (wr && a == 3'd0) begin
      img = lanes(m_ctrl(), i_wb_dat, i_wb_sel);
      n_en = img[0]; n_irq_en = img[1]; n_reload = img[2]; n_psc = img[15:8];
    end
    n_phase   = (!m_en || (wr && a == 3'd0 && i_wb_sel[1])) ? 0 : m_phase + 1;
    n_compare = (wr && a == 3'd2) ? lanes(m_compare, i_wb_dat, i_wb_sel) : m_compare;
`ifdef WB_TIMER_PWM_EN
    n_duty = (wr && a == 3'd4) ? lanes(m_duty, i_wb_dat, i_wb_sel) : m_duty;
    n_pwm  = m_en && (m_count < m_duty);
`else
    n_duty = 32'h0;
    n_pwm  = 1'b0;
`endif
    @(posedge clk);
    if (i_reset) begin
      model_reset();
    end else begin
      m_en = n_en; m_irq_en = n_irq_en; m_reload = n_reload; m_psc = n_psc;
      m_phase = n_phase; m_count = n_count; m_compare = n_compare; m_duty = n_duty;
      m_match = n_match; m_ovf = n_ovf; m_ack = acc; m_pwm = n_pwm; m_rdat = n_rdat;
    end
    #1;
    check_outputs();
  endtask

  task automatic bus_idle();
    i_dev_sel = 1'b0; i_wb_cyc = 1'b0; i_wb_we = 1'b0;
    i_wb_adr = 10'h000; i_wb_dat = 32'h0; i_wb_sel = 4'h0;
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
    i_dev_sel = 1'b1; i_wb_cyc = 1'b1; i_wb_we = 1'b1;
    i_wb_adr = {7'h00, a}; i_wb_dat = d; i_wb_sel = s;
    step();
    bus_idle();
    step();
  endtask

  task automatic wb_read(input logic [2:0] a, output logic [31:0] rd);
    i_dev_sel = 1'b1; i_wb_cyc = 1'b1; i_wb_we = 1'b0;
    i_wb_adr = {7'h00, a}; i_wb_dat = 32'h0; i_wb_sel = 4'h0;
    step();
    rd = o_wb_dat;
    check("rd_ack", 32'(o_wb_ack), 32'd1);
    bus_idle();
    step();
    check("rd_ack_drop", 32'(o_wb_ack), 32'd0);
  endtask

  initial begin
    logic [31:0] rd, d;
    logic [2:0]  a;
    int          highs;

    // Reset state.
    i_reset = 1'b1;
    bus_idle();
    model_reset();
    @(posedge clk); #1;
    check_outputs();
    step(); step();
    i_reset = 1'b0;

    // Every address reads 0 after reset.
    for (int k = 0; k < 8; k++) begin
      wb_read(3'(k), rd);
      check("rst_read", rd, 32'h0);
    end

    // PSC=3, COMPARE=5, RELOAD: COUNT samples 4 clocks apart walk 0..5,0.
    wb_write(3'd2, 32'd5, 4'hf);
    wb_write(3'd0, 32'h0000_0305, 4'hf);
    for (int k = 0; k < 7; k++) begin
      wb_read(3'd1, rd);
      check("reload_seq", rd, (k == 6) ? 32'd0 : 32'(k));
      step(); step();
    end
    wb_read(3'd3, rd);
    check("reload_match", rd & 32'h1, 32'h1);
    wb_write(3'd0, 32'h0, 4'hf);

    // Overflow from all-ones with IRQ_EN.
    wb_write(3'd3, 32'h3, 4'hf);
    wb_write(3'd2, 32'h10, 4'hf);
    wb_write(3'd1, 32'hFFFF_FFFF, 4'hf);
    wb_write(3'd0, 32'h0000_0003, 4'hf);
    check("ovf_irq", 32'(o_irq), 32'd1);
    wb_read(3'd1, rd);
    check("ovf_count", rd, 32'h0);
    wb_read(3'd3, rd);
    check("ovf_status", rd, 32'h2);
    wb_write(3'd0, 32'h0000_0002, 4'hf);

    // MATCH clears by W1C and the interrupt falls.
    wb_write(3'd3, 32'h3, 4'hf);
    wb_write(3'd1, 32'h0, 4'hf);
    wb_write(3'd2, 32'h2, 4'hf);
    wb_write(3'd0, 32'h0000_0003, 4'hf);
    step(); step(); step();
    wb_write(3'd0, 32'h0000_0002, 4'hf);
    check("match_irq", 32'(o_irq), 32'd1);
    wb_write(3'd3, 32'h1, 4'hf);
    check("w1c_irq", 32'(o_irq), 32'd0);
    wb_read(3'd3, rd);
    check("w1c_status", rd, 32'h0);

    // W1C landing on the match tick: the set wins.
    wb_write(3'd1, 32'h0, 4'hf);
    wb_write(3'd2, 32'h0, 4'hf);
    wb_write(3'd0, 32'h0000_0103, 4'hf);
    wb_write(3'd3, 32'h1, 4'hf);
    wb_write(3'd0, 32'h0000_0002, 4'hf);
    wb_read(3'd3, rd);
    check("w1c_race", rd & 32'h1, 32'h1);
    check("w1c_race_irq", 32'(o_irq), 32'd1);

    // Partial COUNT write on a tick cycle: lanes merge, no increment.
    wb_write(3'd0, 32'h0, 4'hf);
    wb_write(3'd3, 32'h3, 4'hf);
    wb_write(3'd2, 32'hFFFF_FFF0, 4'hf);
    wb_write(3'd1, 32'hABCD_0000, 4'hf);
    wb_write(3'd0, 32'h0000_0001, 4'hf);
    wb_write(3'd1, 32'h0000_1234, 4'b0011);
    wb_write(3'd0, 32'h0, 4'hf);
    wb_read(3'd1, rd);
    check("byte_count", rd, 32'hABCD_1236);

    // PWM: COMPARE=9, DUTY=3, RELOAD, PSC=0 -> high 3 of every 10.
    wb_write(3'd2, 32'd9, 4'hf);
    wb_write(3'd4, 32'd3, 4'hf);
    wb_write(3'd1, 32'd0, 4'hf);
    wb_read(3'd4, rd);
`ifdef WB_TIMER_PWM_EN
    check("duty_read", rd, 32'd3);
`else
    check("duty_read", rd, 32'd0);
`endif
    wb_write(3'd0, 32'h0000_0005, 4'hf);
    repeat (12) step();
    highs = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      highs += int'(o_pwm);
    end
`ifdef WB_TIMER_PWM_EN
    check("pwm_highs", 32'(highs), 32'd6);
`else
    check("pwm_highs", 32'(highs), 32'd0);
`endif

    // Reset in the middle of an access.
    i_dev_sel = 1'b1; i_wb_cyc = 1'b1; i_wb_we = 1'b0; i_wb_adr = 10'h000;
    step();
    check("mid_ack", 32'(o_wb_ack), 32'd1);
    i_reset = 1'b1;
    #1;
    model_reset();
    check("mid_rst_ack", 32'(o_wb_ack), 32'd0);
    check("mid_rst_dat", o_wb_dat, 32'h0);
    bus_idle();
    step(); step();
    i_reset = 1'b0;
    wb_read(3'd0, rd);
    check("post_rst_ctrl", rd, 32'h0);

    // Randomized traffic against the model.
    for (int it = 0; it < 700; it++) begin
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      case ($urandom_range(0, 3))
        0: d = 32'($urandom_range(0, 15));
        1: d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: d = d;
      endcase
      if (a == 3'd0) begin
        d[31:16] = 16'h0;
        d[15:8]  = 8'($urandom_range(0, 3));
      end
      i_dev_sel = ($urandom_range(0, 7) != 0);
      i_wb_cyc  = ($urandom_range(0, 7) != 0);
      i_wb_we   = 1'($urandom_range(0, 1));
      i_wb_adr  = {7'($urandom), a};
      i_wb_dat  = d;
      i_wb_sel  = 4'($urandom);
      repeat ($urandom_range(1, 3)) step();
      bus_idle();
      repeat ($urandom_range(0, 2)) step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
